// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction/operand registers and fetch-phase sequencer.
// Optional FETCH_TRACE_EN adds a saturating instr_count output.
module fetch_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              pc_src,
  input  logic              pc_write_cond,
  input  logic              IR_write,
  input  logic              TRLD,
  input  logic              IorD,
  input  logic              cond_flag,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        opCode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] tr,
  output logic [ADDR_W-1:0] target,
`ifdef FETCH_TRACE_EN
  output logic [15:0]       instr_count,
`endif
  output logic              seq_err
);

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_OPND = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              err_set;
  logic              tr_load;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;

  assign opCode   = ir[7:4];
  assign target   = {ir[3:0], tr};
  assign mem_addr = IorD ? target : pc;
  assign pc_next  = pc_src ? target : pc + 12'd1;
  assign pc_load  = pc_write | (pc_write_cond & cond_flag);

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    tr_load = 1'b0;
    if (IR_write) begin
      state_d = S_OPND;
      err_set = TRLD;
    end else if (TRLD) begin
      // An out-of-phase operand still loads; only the flag records the slip.
      tr_load = 1'b1;
      if (state_q == S_OPND) state_d = S_EXEC;
      else                   err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OP;
      pc      <= '0;
      ir      <= '0;
      tr      <= '0;
      seq_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_load)  pc <= pc_next;
      if (IR_write) ir <= mem_rdata;
      if (tr_load)  tr <= mem_rdata;
      if (err_set)  seq_err <= 1'b1;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_count <= '0;
    end else if (IR_write && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized strobes against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 0, pc_src = 0, pc_write_cond = 0, IR_write = 0;
  logic        TRLD = 0, IorD = 0, cond_flag = 0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [3:0]  opCode;
  logic [11:0] mem_addr, pc, target;
  logic [7:0]  ir, tr;
  logic        seq_err;
`ifdef FETCH_TRACE_EN
  logic [15:0] instr_count;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
    .pc_write_cond(pc_write_cond), .IR_write(IR_write), .TRLD(TRLD),
    .IorD(IorD), .cond_flag(cond_flag), .mem_rdata(mem_rdata),
    .opCode(opCode), .mem_addr(mem_addr), .pc(pc), .ir(ir), .tr(tr),
    .target(target),
`ifdef FETCH_TRACE_EN
    .instr_count(instr_count),
`endif
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: plain integers, phase tracked as "what has been fetched".
  int  m_pc, m_ir, m_tr, m_cnt;
  bit  m_err;
  bit  m_have_op, m_have_opnd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic r, input logic pw, input logic ps, input logic pwc,
                     input logic irw, input logic trld, input logic iord,
                     input logic cf, input logic [7:0] md);
    rst = r; pc_write = pw; pc_src = ps; pc_write_cond = pwc;
    IR_write = irw; TRLD = trld; IorD = iord; cond_flag = cf; mem_rdata = md;
  endtask

  task automatic model_edge();
    int  tgt, npc;
    bit  in_opnd;
    if (!rst) begin
      m_pc = 0; m_ir = 0; m_tr = 0; m_err = 0; m_cnt = 0;
      m_have_op = 0; m_have_opnd = 0;
    end else begin
      tgt = (m_ir % 16) * 256 + m_tr;
      npc = pc_src ? tgt : (m_pc + 1) % 4096;
      in_opnd = m_have_op && !m_have_opnd;
      if (pc_write || (pc_write_cond && cond_flag)) m_pc = npc;
      if ((TRLD && !in_opnd) || (IR_write && TRLD)) m_err = 1;
      if (IR_write) begin
        m_ir = mem_rdata;
        m_have_op = 1; m_have_opnd = 0;
        if (m_cnt < 65535) m_cnt++;
      end else if (TRLD) begin
        m_tr = mem_rdata;
        if (in_opnd) m_have_opnd = 1;
      end
    end
  endtask

  task automatic cycle();
    int tgt;
    @(posedge clk);
    model_edge();
    #1;
    tgt = (m_ir % 16) * 256 + m_tr;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("tr", 32'(tr), 32'(m_tr));
    chk("seq_err", 32'(seq_err), 32'(m_err));
    chk("opCode", 32'(opCode), 32'(m_ir / 16));
    chk("target", 32'(target), 32'(tgt));
    chk("mem_addr", 32'(mem_addr), 32'(IorD ? tgt : m_pc));
`ifdef FETCH_TRACE_EN
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
`endif
  endtask

  task automatic idle();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    // Reset, then opcode 0x5A
    drv(0, 1, 1, 1, 1, 1, 1, 1, 8'hFF); cycle();
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_seq_err", 32'(seq_err), 32'h0);
    drv(1, 0, 0, 0, 1, 0, 0, 0, 8'h5A); cycle();
    chk("ir_5a", 32'(ir), 32'h5A);
    chk("op_5", 32'(opCode), 32'h5);
    chk("tgt_hi_a", 32'(target[11:8]), 32'hA);

    // PC wrap: target 0xFFF, jump there, then increment
    drv(1, 0, 0, 0, 1, 0, 0, 0, 8'h0F); cycle();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 8'hFF); cycle();
    drv(1, 1, 1, 0, 0, 0, 0, 0, 8'h00); cycle();
    chk("pc_fff", 32'(pc), 32'hFFF);
    drv(1, 1, 0, 0, 0, 0, 0, 0, 8'h00); cycle();
    chk("pc_wrap", 32'(pc), 32'h000);

    // Conditional jump to 0x321
    drv(1, 0, 0, 0, 1, 0, 0, 0, 8'hC3); cycle();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 8'h21); cycle();
    drv(1, 0, 1, 1, 0, 0, 0, 0, 8'h00); cycle();
    chk("cond0_hold", 32'(pc), 32'h000);
    drv(1, 0, 1, 1, 0, 0, 0, 1, 8'h00); cycle();
    chk("cond1_jump", 32'(pc), 32'h321);

    // Address mux
    drv(1, 0, 0, 0, 1, 0, 0, 0, 8'h12); cycle();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 8'h34); cycle();
    drv(1, 0, 0, 0, 0, 0, 1, 0, 8'h00); #1;
    chk("addr_iord1", 32'(mem_addr), 32'h234);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 8'h00); #1;
    chk("addr_iord0", 32'(mem_addr), 32'h321);
    chk("no_err_yet", 32'(seq_err), 32'h0);

    // TRLD right after reset
    drv(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); cycle();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 8'h77); cycle();
    chk("err_trld_op", 32'(seq_err), 32'h1);
    idle(); cycle(); cycle();
    chk("err_sticky", 32'(seq_err), 32'h1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); cycle();
    chk("err_cleared", 32'(seq_err), 32'h0);

    // Simultaneous IR_write/TRLD
    drv(1, 0, 0, 0, 1, 0, 0, 0, 8'h40); cycle();
    drv(1, 0, 0, 0, 0, 1, 0, 0, 8'h99); cycle();
    chk("tr_99", 32'(tr), 32'h99);
    drv(1, 0, 0, 0, 1, 1, 0, 0, 8'h66); cycle();
    chk("err_both", 32'(seq_err), 32'h1);
    chk("tr_kept", 32'(tr), 32'h99);
    chk("ir_both", 32'(ir), 32'h66);

`ifdef FETCH_TRACE_EN
    drv(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); cycle();
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 0, 1, 0, 0, 0, 8'h10 + 8'(i)); cycle();
      idle(); cycle();
    end
    chk("cnt_3", 32'(instr_count), 32'd3);
    drv(0, 1, 0, 0, 0, 1, 0, 0, 8'h00); cycle();
    chk("cnt_0", 32'(instr_count), 32'd0);
    chk("pc_0_after_rst", 32'(pc), 32'h000);
`endif

    // Randomized strobes
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
